// File: rtl/prf_ram_scoreboard.sv
// Physical register file with per-entry ready scoreboard, write-to-read bypass,
// write-collision flag and a multi-cycle banked initialisation sequence.
module prf_ram_scoreboard #(
   parameter int RPORT        = 4,
   parameter int WPORT        = 2,
   parameter int APORT        = 2,
   parameter int DEPTH        = 64,
   parameter int INDEX        = 6,
   parameter int WIDTH        = 32,
   parameter int INIT_LANES   = 8,
   parameter int READ_LATENCY = 0,
   parameter int BYPASS       = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [RPORT*INDEX-1:0]   rd_addr_i,
   output logic [RPORT*WIDTH-1:0]   rd_data_o,
   output logic [RPORT-1:0]         rd_ready_o,
   input  logic [WPORT-1:0]         wr_en_i,
   input  logic [WPORT*INDEX-1:0]   wr_addr_i,
   input  logic [WPORT*WIDTH-1:0]   wr_data_i,
   input  logic [APORT-1:0]         alloc_en_i,
   input  logic [APORT*INDEX-1:0]   alloc_addr_i,
   output logic                     init_busy_o,
   output logic                     wr_collision_o
);

   // state | meaning
   // INIT  | clearing INIT_LANES entries per cycle; ports ignored, reads forced to 0
   // RUN   | normal write / allocate / read operation

   localparam int GROUPS = DEPTH / INIT_LANES;
   localparam int CNTW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [INDEX:0] DEPTH_W = (INDEX+1)'(DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              run;
   logic              init_last;
   logic              coll_q, coll_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              rdy_q [DEPTH];
   logic [RPORT*WIDTH-1:0] comb_data, src_data;
   logic [RPORT-1:0]       comb_rdy, src_rdy;

   function automatic logic in_range(input logic [INDEX-1:0] a);
      return {1'b0, a} < DEPTH_W;
   endfunction

   function automatic logic [CNTW-1:0] group_of(input logic [INDEX-1:0] a);
      return CNTW'(int'(a) / INIT_LANES);
   endfunction

   assign init_last = (cnt_q == CNTW'(GROUPS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (init_last) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      init_busy_o = (state_q == S_INIT);
      run         = (state_q == S_RUN);
   end

   // One update block per entry; later write ports override earlier ones and allocs.
   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      always_ff @(posedge clk) begin
         if (!reset) begin
            if (!run) begin
               if (cnt_q == CNTW'(e / INIT_LANES)) begin
                  mem_q[e] <= '0;
                  rdy_q[e] <= 1'b1;
               end
            end else begin
               for (int a = 0; a < APORT; a++)
                  if (alloc_en_i[a] && alloc_addr_i[a*INDEX +: INDEX] == INDEX'(e))
                     rdy_q[e] <= 1'b0;
               for (int w = 0; w < WPORT; w++)
                  if (wr_en_i[w] && wr_addr_i[w*INDEX +: INDEX] == INDEX'(e)) begin
                     mem_q[e] <= wr_data_i[w*WIDTH +: WIDTH];
                     rdy_q[e] <= 1'b1;
                  end
            end
         end
      end
   end

   always_comb begin
      coll_d = 1'b0;
      for (int i = 0; i < WPORT; i++)
         for (int j = i + 1; j < WPORT; j++)
            if (wr_en_i[i] && wr_en_i[j] &&
                wr_addr_i[i*INDEX +: INDEX] == wr_addr_i[j*INDEX +: INDEX])
               coll_d = 1'b1;
      if (!run) coll_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) coll_q <= 1'b0;
      else       coll_q <= coll_d;
   end

   assign wr_collision_o = coll_q;

   // Combinational read value; with a registered read this is the post-edge array state.
   always_comb begin
      logic [INDEX-1:0] a;
      a         = '0;
      comb_data = '0;
      comb_rdy  = '0;
      for (int p = 0; p < RPORT; p++) begin
         a = rd_addr_i[p*INDEX +: INDEX];
         if (in_range(a)) begin
            comb_data[p*WIDTH +: WIDTH] = mem_q[a];
            comb_rdy[p]                 = rdy_q[a];
            if (READ_LATENCY != 0) begin
               if (!run) begin
                  if (group_of(a) == cnt_q) begin
                     comb_data[p*WIDTH +: WIDTH] = '0;
                     comb_rdy[p]                 = 1'b1;
                  end
               end else begin
                  for (int k = 0; k < APORT; k++)
                     if (alloc_en_i[k] && alloc_addr_i[k*INDEX +: INDEX] == a)
                        comb_rdy[p] = 1'b0;
                  for (int w = 0; w < WPORT; w++)
                     if (wr_en_i[w] && wr_addr_i[w*INDEX +: INDEX] == a) begin
                        comb_data[p*WIDTH +: WIDTH] = wr_data_i[w*WIDTH +: WIDTH];
                        comb_rdy[p]                 = 1'b1;
                     end
               end
            end else if (BYPASS != 0) begin
               for (int w = 0; w < WPORT; w++)
                  if (wr_en_i[w] && wr_addr_i[w*INDEX +: INDEX] == a) begin
                     comb_data[p*WIDTH +: WIDTH] = wr_data_i[w*WIDTH +: WIDTH];
                     comb_rdy[p]                 = 1'b1;
                  end
            end
         end
      end
   end

   if (READ_LATENCY != 0) begin : g_reg
      logic [RPORT*WIDTH-1:0] rd_data_q;
      logic [RPORT-1:0]       rd_ready_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_data_q  <= '0;
            rd_ready_q <= '0;
         end else begin
            rd_data_q  <= comb_data;
            rd_ready_q <= comb_rdy;
         end
      end
      assign src_data = rd_data_q;
      assign src_rdy  = rd_ready_q;
   end else begin : g_comb
      assign src_data = comb_data;
      assign src_rdy  = comb_rdy;
   end

   assign rd_data_o  = run ? src_data : '0;
   assign rd_ready_o = run ? src_rdy  : '0;

endmodule

// File: tb/tb_prf_ram_scoreboard.sv
// Bench for prf_ram_scoreboard: three configurations (bypass, no bypass, registered
// read) share one stimulus stream and are checked against an abstract array model.
module tb_prf_ram_scoreboard;
   localparam int RP = 4, WP = 2, AP = 2, D = 64, IX = 6, W = 32, GR = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [RP*IX-1:0]    rd_addr;
   logic [WP-1:0]       wr_en;
   logic [WP*IX-1:0]    wr_addr;
   logic [WP*W-1:0]     wr_data;
   logic [AP-1:0]       alloc_en;
   logic [AP*IX-1:0]    alloc_addr;

   logic [RP*W-1:0] d0_data, nb_data, l1_data;
   logic [RP-1:0]   d0_rdy, nb_rdy, l1_rdy;
   logic            d0_busy, nb_busy, l1_busy, d0_coll, nb_coll, l1_coll;

   prf_ram_scoreboard #(.READ_LATENCY(0), .BYPASS(1)) u_dut (
      .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(d0_data), .rd_ready_o(d0_rdy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
      .alloc_addr_i(alloc_addr), .init_busy_o(d0_busy), .wr_collision_o(d0_coll));
   prf_ram_scoreboard #(.READ_LATENCY(0), .BYPASS(0)) u_nb (
      .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(nb_data), .rd_ready_o(nb_rdy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
      .alloc_addr_i(alloc_addr), .init_busy_o(nb_busy), .wr_collision_o(nb_coll));
   prf_ram_scoreboard #(.READ_LATENCY(1), .BYPASS(1)) u_l1 (
      .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(l1_data), .rd_ready_o(l1_rdy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
      .alloc_addr_i(alloc_addr), .init_busy_o(l1_busy), .wr_collision_o(l1_coll));

   logic [31:0] m_data [D];
   bit          m_rdy  [D];
   bit          m_busy, m_coll, m_valid, busy_pre;
   int          m_left;
   int          n_cmp = 0, n_mis = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void exp_comb(int p, bit byp, output logic [31:0] d, output logic r);
      int a;
      a = int'(rd_addr[p*IX +: IX]);
      d = '0;
      r = 1'b0;
      if (m_busy) return;
      d = m_data[a];
      r = m_rdy[a];
      if (byp)
         for (int w = 0; w < WP; w++)
            if (wr_en[w] && int'(wr_addr[w*IX +: IX]) == a) begin
               d = wr_data[w*W +: W];
               r = 1'b1;
            end
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_busy = 1; m_left = GR; m_coll = 0; m_valid = 1;
      end else if (!m_valid) begin
         m_coll = 0;
      end else if (m_busy) begin
         m_coll = 0;
         m_left--;
         if (m_left == 0) begin
            for (int e = 0; e < D; e++) begin m_data[e] = '0; m_rdy[e] = 1; end
            m_busy = 0;
         end
      end else begin
         m_coll = 0;
         for (int i = 0; i < WP; i++)
            for (int j = i + 1; j < WP; j++)
               if (wr_en[i] && wr_en[j] && wr_addr[i*IX +: IX] == wr_addr[j*IX +: IX]) m_coll = 1;
         for (int k = 0; k < AP; k++)
            if (alloc_en[k]) m_rdy[int'(alloc_addr[k*IX +: IX])] = 0;
         for (int w = 0; w < WP; w++)
            if (wr_en[w]) begin
               m_data[int'(wr_addr[w*IX +: IX])] = wr_data[w*W +: W];
               m_rdy[int'(wr_addr[w*IX +: IX])]  = 1;
            end
      end
   endtask

   task automatic step();
      logic [31:0] d;
      logic        r;
      int          a;
      #1;
      busy_pre = d0_busy;
      if (m_valid)
         for (int p = 0; p < RP; p++) begin
            exp_comb(p, 1, d, r);
            chk($sformatf("byp_data[%0d]", p), d0_data[p*W +: W], d);
            chk($sformatf("byp_rdy[%0d]", p), 32'(d0_rdy[p]), 32'(r));
            exp_comb(p, 0, d, r);
            chk($sformatf("nobyp_data[%0d]", p), nb_data[p*W +: W], d);
            chk($sformatf("nobyp_rdy[%0d]", p), 32'(nb_rdy[p]), 32'(r));
         end
      @(posedge clk);
      model_edge();
      #1;
      if (m_valid) begin
         for (int p = 0; p < RP; p++) begin
            a = int'(rd_addr[p*IX +: IX]);
            d = m_busy ? 32'h0 : m_data[a];
            r = m_busy ? 1'b0 : m_rdy[a];
            chk($sformatf("lat1_data[%0d]", p), l1_data[p*W +: W], d);
            chk($sformatf("lat1_rdy[%0d]", p), 32'(l1_rdy[p]), 32'(r));
         end
         chk("coll_byp", 32'(d0_coll), 32'(m_coll));
         chk("coll_nobyp", 32'(nb_coll), 32'(m_coll));
         chk("coll_lat1", 32'(l1_coll), 32'(m_coll));
         chk("busy_byp", 32'(d0_busy), 32'(m_busy));
         chk("busy_nobyp", 32'(nb_busy), 32'(m_busy));
         chk("busy_lat1", 32'(l1_busy), 32'(m_busy));
      end
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = '0; alloc_en = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
      m_valid = 0; m_busy = 0; m_coll = 0; m_left = 0;
      @(negedge clk);
      repeat (3) step();
      reset = 0;
      n = 0;
      repeat (12) begin rd_addr = RP*IX'($urandom); step(); if (busy_pre) n++; end
      chk("init_len", n, 8);

      for (int b = 0; b < D / RP; b++) begin
         for (int p = 0; p < RP; p++) rd_addr[p*IX +: IX] = IX'(b*RP + p);
         step();
      end

      // bypassed write to entry 5 read on port 2
      rd_addr = '0; rd_addr[2*IX +: IX] = 6'd5;
      wr_en = 2'b01; wr_addr[0 +: IX] = 6'd5; wr_data[0 +: W] = 32'hDEADBEEF;
      step();
      chk("lat1_wr5", l1_data[2*W +: W], 32'hDEADBEEF);
      chk("nobyp_wr5_next", nb_data[2*W +: W], 32'hDEADBEEF);
      idle();
      step();

      rd_addr[0 +: IX] = 6'd12;
      alloc_en = 2'b01; alloc_addr[0 +: IX] = 6'd12;
      step();
      chk("alloc12_rdy", 32'(l1_rdy[0]), 32'd0);
      idle(); step();
      wr_en = 2'b10; wr_addr[IX +: IX] = 6'd12; wr_data[W +: W] = 32'h1234;
      step();
      chk("wr12_data", l1_data[0 +: W], 32'h1234);
      alloc_en = 2'b10; alloc_addr[IX +: IX] = 6'd12;
      wr_en = 2'b01; wr_addr[0 +: IX] = 6'd12; wr_data[0 +: W] = 32'h777;
      step();
      chk("alloc_wr12_rdy", 32'(l1_rdy[0]), 32'd1);
      idle();

      rd_addr[IX +: IX] = 6'd7;
      wr_en = 2'b11; wr_addr = {6'd7, 6'd7}; wr_data = {32'hBBBB, 32'hAAAA};
      step();
      chk("coll_pulse", 32'(d0_coll), 32'd1);
      chk("coll_winner", l1_data[W +: W], 32'hBBBB);
      idle(); step();
      chk("coll_clear", 32'(d0_coll), 32'd0);

      // registered read coinciding with a write, then reset clears the register
      rd_addr[0 +: IX] = 6'd9;
      wr_en = 2'b10; wr_addr[IX +: IX] = 6'd9; wr_data[W +: W] = 32'h55;
      step();
      chk("lat1_wr9", l1_data[0 +: W], 32'h55);
      idle();
      reset = 1; step();
      chk("lat1_reset", l1_data[0 +: W], 32'h0);
      reset = 0;
      repeat (4) step();
      reset = 1; step(); reset = 0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 3) begin wr_en = 2'b01; wr_addr[0 +: IX] = 6'd3; wr_data[0 +: W] = 32'hFFFF; end
         else idle();
         step();
         if (busy_pre) n++;
      end
      chk("init_len_restart", n, 8);
      rd_addr[3*IX +: IX] = 6'd3;
      step();
      chk("init_discard3", l1_data[3*W +: W], 32'h0);

      for (int it = 0; it < 400; it++) begin
         reset = ($urandom_range(0, 99) == 0);
         wr_en = WP'($urandom); alloc_en = AP'($urandom);
         for (int w = 0; w < WP; w++) begin
            wr_addr[w*IX +: IX] = IX'($urandom_range(0, 15));
            wr_data[w*W +: W]   = $urandom;
         end
         for (int k = 0; k < AP; k++) alloc_addr[k*IX +: IX] = IX'($urandom_range(0, 15));
         for (int p = 0; p < RP; p++)
            rd_addr[p*IX +: IX] = IX'(($urandom_range(0, 3) == 0) ? $urandom_range(0, D-1)
                                                                  : $urandom_range(0, 15));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/prf_ram_scoreboard.md
Name: prf_ram_scoreboard

Overview:
- Parametrised next-generation physical register file.
- Has generic read/write port counts, packed port vectors and optional registered read.
- Adds write-to-read bypass, a per-entry ready scoreboard (cleared on rename allocation, set on writeback), write-collision detection, and a multi-cycle initialisation FSM that replaces single-cycle array clear.
- Sits between rename/issue (alloc, ready lookup) and register-read/writeback stages.

Parameters:
- RPORT, 4, number of read ports
- WPORT, 2, number of write (writeback) ports
- APORT, 2, number of allocation ports (clear ready bit)
- DEPTH, 64, number of entries; must be a multiple of INIT_LANES
- INDEX, 6, address width, equal to clog2(DEPTH)
- WIDTH, 32, data width
- INIT_LANES, 8, entries cleared per cycle during INIT
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read
- BYPASS, 1, 1 = same-cycle write data/ready forwarded to matching reads

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_addr_i  in  RPORT*INDEX  packed read addresses; port p is at bits [p*INDEX +: INDEX]
- rd_data_o  out  RPORT*WIDTH  packed read data
- rd_ready_o  out  RPORT  ready bit of each read entry
- wr_en_i  in  WPORT  write enables
- wr_addr_i  in  WPORT*INDEX  packed write addresses
- wr_data_i  in  WPORT*WIDTH  packed write data
- alloc_en_i  in  APORT  allocation enables
- alloc_addr_i  in  APORT*INDEX  entries to mark not-ready
- init_busy_o  out  1  high while INIT is in progress
- wr_collision_o  out  1  registered pulse: two enabled write ports targeted one address in the previous cycle

Behaviour:
- Reset is clocked by clk. A cycle with reset=1 at the edge does the following:
  - state <= INIT, clear counter <= 0.
  - init_busy_o <= 1, wr_collision_o <= 0.
  - Read pipeline registers <= 0.
- FSM states:
  - INIT: each cycle writes data 0 and ready=1 to entries [cnt*INIT_LANES, cnt*INIT_LANES+INIT_LANES-1], then cnt++. After the last group (cnt == DEPTH/INIT_LANES-1), next state is RUN and init_busy_o <= 0.
  - Reset held high keeps cnt at 0.
  - Reset asserted in any state, including mid-INIT, restarts INIT from entry 0.
  - Init time after reset deasserts is DEPTH/INIT_LANES cycles (8 at defaults).
- While in INIT:
  - wr_en_i and alloc_en_i are ignored.
  - rd_data_o = 0 and rd_ready_o = 0 for all ports, both latencies.
  - wr_collision_o stays 0.
- RUN, write:
  - Each enabled write port stores data and sets ready=1 at the clock edge.
  - Same-address writes: the highest-numbered enabled port wins.
- RUN, allocate:
  - Each enabled alloc port clears ready at the clock edge; data is unchanged.
  - Write and alloc to the same address in one cycle: the write wins (ready=1).
- RUN, read with READ_LATENCY=0:
  - rd_data_o/rd_ready_o are combinational from the array.
  - With BYPASS=1, a read address matching an enabled write address returns that write's data and ready=1; the highest-numbered matching write port wins.
  - A matching alloc in the same cycle is not forwarded (old ready is shown).
  - With BYPASS=0, the pre-write value is returned.
- RUN, read with READ_LATENCY=1:
  - The address is sampled at edge N; data is visible after edge N.
  - The value returned is the post-edge-N array state, because the bypass is built into the registered path.
  - This holds regardless of BYPASS.
- Collision detection:
  - wr_collision_o is 1 in the cycle after any pair of enabled write ports shares an address in RUN; otherwise 0.
  - It is a single-cycle pulse per offending cycle.
- Widths: all addresses are < DEPTH. Out-of-range addresses (DEPTH not a power of 2) are ignored on write and read 0/not-ready.

Test Plan:
- Reset high 3 cycles then low: init_busy_o=1 for exactly 8 cycles after deassert, then 0. Every entry reads data 0, ready 1. Reads during INIT return 0/0.
- RUN: write port0 addr 5 data 0xDEADBEEF while read port2 addr 5 (LAT=0, BYPASS=1): same cycle rd_data=0xDEADBEEF, rd_ready=1. Same test with BYPASS=0: returns 0, then 0xDEADBEEF next cycle.
- alloc addr 12, next cycle read 12: ready=0, data unchanged. Write 0x1234 to 12: ready=1. Alloc+write 12 same cycle: ready=1.
- wr port0 addr 7 = 0xAAAA and port1 addr 7 = 0xBBBB same cycle: entry 7 = 0xBBBB; wr_collision_o=1 for one cycle only.
- Reset asserted mid-INIT (cnt=4) then released: INIT restarts, 8 further busy cycles. A write attempted during INIT to addr 3 is discarded (reads 0 after INIT).
- READ_LATENCY=1: read addr 9 at edge N coinciding with write 0x55 to 9: output 0x55/ready 1 after edge N. Reset zeroes the output register next edge.
